// File: rtl/diff_bbox_detect_pkg.sv
// Shared constants and types for the frame-difference bounding-box blocks.
package diff_pkg;

    localparam int IMG_W_DEF   = 640;
    localparam int IMG_H_DEF   = 480;
    localparam int MIN_PIX_DEF = 16;
    localparam int COORD_W     = 11;
    localparam int FG_BIT      = 7;
    localparam int CNT_W       = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        LATCH  = 2'd2
    } state_t;

endpackage

// File: rtl/diff_bbox_detect_sync_edge_det.sv
// Registers vsync/href once and flags the frame-start and line-end edges.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    input  logic href,
    output logic vs_rise,
    output logic hs_fall
);

    logic vsync_d;
    logic href_d;

    // NOTE: clocked state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            vsync_d <= vsync;
            href_d  <= href;
        end
    end

    assign vs_rise = vsync & ~vsync_d;
    assign hs_fall = ~href & href_d;

endmodule

// File: rtl/diff_bbox_detect.sv
// Per-frame foreground bounding box and pixel count, latched at each vsync rise.
// Optional rectangle overlay output stream enabled by DIFF_BBOX_OVERLAY_EN.
module diff_bbox_detect
    import diff_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int MIN_PIX = MIN_PIX_DEF,
    parameter int CW      = COORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic [7:0]       per_img_Bit,
    output logic             post_box_valid,
    output logic [CW-1:0]    box_x_min,
    output logic [CW-1:0]    box_x_max,
    output logic [CW-1:0]    box_y_min,
    output logic [CW-1:0]    box_y_max,
    output logic             box_found,
    output logic [CNT_W-1:0] pix_count
`ifdef DIFF_BBOX_OVERLAY_EN
    ,
    output logic             ovl_frame_vsync,
    output logic             ovl_frame_href,
    output logic             ovl_frame_clken,
    output logic [7:0]       ovl_img
`endif
);

    localparam logic [CW-1:0]    X_LIM   = CW'(IMG_W);
    localparam logic [CW-1:0]    Y_LIM   = CW'(IMG_H);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIX);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic vs_rise;
    logic hs_fall;

    sync_edge_det u_sync (
        .clk     (clk),
        .rst     (rst),
        .vsync   (per_frame_vsync),
        .href    (per_frame_href),
        .vs_rise (vs_rise),
        .hs_fall (hs_fall)
    );

    logic [CW-1:0] x_cnt;
    logic [CW-1:0] y_cnt;
    logic          pix_en;
    logic          fg_hit;

    assign pix_en = per_frame_clken & per_frame_href;
    assign fg_hit = pix_en & per_img_Bit[FG_BIT] & (x_cnt < X_LIM) & (y_cnt < Y_LIM);

    // Counters saturate at the limit so stray long lines or extra lines stay out of range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (hs_fall || vs_rise)
                x_cnt <= '0;
            else if (pix_en && x_cnt != X_LIM)
                x_cnt <= x_cnt + 1'b1;

            if (vs_rise)
                y_cnt <= '0;
            else if (hs_fall && y_cnt != Y_LIM)
                y_cnt <= y_cnt + 1'b1;
        end
    end

    state_t            state;
    logic              acc_clr;
    logic [CW-1:0]     acc_x_min, acc_x_max, acc_y_min, acc_y_max;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CW-1:0]     nx_x_min, nx_x_max, nx_y_min, nx_y_max;
    logic [CNT_W-1:0]  nx_cnt;

    // Clear first, then fold in the current pixel, so a pixel on the LATCH cycle opens the new frame.
    // NOTE: every always_comb output gets a default up front so no path can infer a latch.
    always_comb begin
        acc_clr  = (state == LATCH) || (state == IDLE && vs_rise);
        nx_x_min = acc_clr ? '1 : acc_x_min;
        nx_x_max = acc_clr ? '0 : acc_x_max;
        nx_y_min = acc_clr ? '1 : acc_y_min;
        nx_y_max = acc_clr ? '0 : acc_y_max;
        nx_cnt   = acc_clr ? '0 : acc_cnt;
        if (fg_hit) begin
            if (x_cnt < nx_x_min) nx_x_min = x_cnt;
            if (x_cnt > nx_x_max) nx_x_max = x_cnt;
            if (y_cnt < nx_y_min) nx_y_min = y_cnt;
            if (y_cnt > nx_y_max) nx_y_max = y_cnt;
            if (nx_cnt != CNT_MAX) nx_cnt = nx_cnt + 1'b1;
        end
    end

    // NOTE: accumulators are plain registers, so they take the async reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_x_min <= '1;
            acc_x_max <= '0;
            acc_y_min <= '1;
            acc_y_max <= '0;
            acc_cnt   <= '0;
        end else begin
            acc_x_min <= nx_x_min;
            acc_x_max <= nx_x_max;
            acc_y_min <= nx_y_min;
            acc_y_max <= nx_y_max;
            acc_cnt   <= nx_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            post_box_valid <= 1'b0;
            box_x_min      <= '0;
            box_x_max      <= '0;
            box_y_min      <= '0;
            box_y_max      <= '0;
            box_found      <= 1'b0;
            pix_count      <= '0;
        end else begin
            post_box_valid <= 1'b0;
            case (state)
                IDLE:   if (vs_rise) state <= ACTIVE;
                ACTIVE: if (vs_rise) state <= LATCH;
                LATCH: begin
                    state          <= ACTIVE;
                    post_box_valid <= 1'b1;
                    box_found      <= (acc_cnt >= MIN_CNT);
                    pix_count      <= acc_cnt;
                    // An empty frame reports a zero box instead of the all-ones clear value.
                    if (acc_cnt == '0) begin
                        box_x_min <= '0;
                        box_x_max <= '0;
                        box_y_min <= '0;
                        box_y_max <= '0;
                    end else begin
                        box_x_min <= acc_x_min;
                        box_x_max <= acc_x_max;
                        box_y_min <= acc_y_min;
                        box_y_max <= acc_y_max;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DIFF_BBOX_OVERLAY_EN
    logic on_v_edge;
    logic on_h_edge;

    assign on_v_edge = (x_cnt == box_x_min || x_cnt == box_x_max)
                       && y_cnt >= box_y_min && y_cnt <= box_y_max;
    assign on_h_edge = (y_cnt == box_y_min || y_cnt == box_y_max)
                       && x_cnt >= box_x_min && x_cnt <= box_x_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovl_frame_vsync <= 1'b0;
            ovl_frame_href  <= 1'b0;
            ovl_frame_clken <= 1'b0;
            ovl_img         <= 8'd0;
        end else begin
            ovl_frame_vsync <= per_frame_vsync;
            ovl_frame_href  <= per_frame_href;
            ovl_frame_clken <= per_frame_clken;
            ovl_img         <= (pix_en && box_found && (on_v_edge || on_h_edge))
                               ? 8'd128 : per_img_Bit;
        end
    end
`endif

endmodule

// File: tb/tb_diff_bbox_detect.sv
// Directed bench for diff_bbox_detect on an 8x4 image; overlay checks when DIFF_BBOX_OVERLAY_EN is set.
module tb_diff_bbox_detect;
    import diff_pkg::*;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int CWB = COORD_W;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [7:0] pix = 8'd0;

    logic             a_valid, b_valid, a_found, b_found;
    logic [CWB-1:0]   a_xmin, a_xmax, a_ymin, a_ymax;
    logic [CWB-1:0]   b_xmin, b_xmax, b_ymin, b_ymax;
    logic [CNT_W-1:0] a_cnt, b_cnt;
`ifdef DIFF_BBOX_OVERLAY_EN
    logic       a_ov_vs, a_ov_hr, a_ov_ck, b_ov_vs, b_ov_hr, b_ov_ck;
    logic [7:0] a_ov_img, b_ov_img;
`endif

    always #5 clk = ~clk;

    diff_bbox_detect #(.IMG_W(W), .IMG_H(H), .MIN_PIX(1), .CW(CWB)) dut_a (
        .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
        .per_frame_clken(clken), .per_img_Bit(pix), .post_box_valid(a_valid),
        .box_x_min(a_xmin), .box_x_max(a_xmax), .box_y_min(a_ymin), .box_y_max(a_ymax),
        .box_found(a_found), .pix_count(a_cnt)
`ifdef DIFF_BBOX_OVERLAY_EN
        , .ovl_frame_vsync(a_ov_vs), .ovl_frame_href(a_ov_hr),
        .ovl_frame_clken(a_ov_ck), .ovl_img(a_ov_img)
`endif
    );

    diff_bbox_detect #(.IMG_W(W), .IMG_H(H), .MIN_PIX(16), .CW(CWB)) dut_b (
        .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
        .per_frame_clken(clken), .per_img_Bit(pix), .post_box_valid(b_valid),
        .box_x_min(b_xmin), .box_x_max(b_xmax), .box_y_min(b_ymin), .box_y_max(b_ymax),
        .box_found(b_found), .pix_count(b_cnt)
`ifdef DIFF_BBOX_OVERLAY_EN
        , .ovl_frame_vsync(b_ov_vs), .ovl_frame_href(b_ov_hr),
        .ovl_frame_clken(b_ov_ck), .ovl_img(b_ov_img)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int npulse, first_at;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        string            name;
        logic [4:0][9:0]  mask;
        logic [4:0]       no_clk;
        int               nl, len;
        logic [7:0]       fg, bg;
        int               xmin, xmax, ymin, ymax, cnt;
        bit               f1, f16;
    } vec_t;

    vec_t vt[6];

    function automatic vec_t mk(string n, int nl, int len, logic [7:0] bg,
                                int xmin, int xmax, int ymin, int ymax, int cnt,
                                bit f1, bit f16);
        vec_t v;
        v.name = n; v.mask = '0; v.no_clk = '0; v.nl = nl; v.len = len;
        v.fg = 8'hFF; v.bg = bg;
        v.xmin = xmin; v.xmax = xmax; v.ymin = ymin; v.ymax = ymax; v.cnt = cnt;
        v.f1 = f1; v.f16 = f16;
        return v;
    endfunction

    task automatic drive_frame(input vec_t v);
        for (int y = 0; y < v.nl; y++) begin
            for (int x = 0; x < v.len; x++) begin
                @(negedge clk);
                href  = 1'b1;
                clken = ~v.no_clk[y];
                pix   = v.mask[y][x] ? v.fg : v.bg;
            end
            @(negedge clk);
            href = 1'b0; clken = 1'b0; pix = 8'd0;
            @(negedge clk);
        end
    endtask

    // Raise vsync for high_cycles and count post_box_valid pulses over a fixed window.
    task automatic frame_boundary(input int high_cycles);
        @(negedge clk);
        vsync = 1'b1;
        npulse = 0; first_at = -1;
        for (int i = 1; i <= high_cycles + 4; i++) begin
            @(negedge clk);
            if (a_valid) begin
                npulse++;
                if (first_at < 0) first_at = i;
            end
            if (i == high_cycles) vsync = 1'b0;
        end
    endtask

    function automatic bit on_border(int x, int y);
        return ((x == 1 || x == 3) && y >= 1 && y <= 2) ||
               ((y == 1 || y == 2) && x >= 1 && x <= 3);
    endfunction

    initial begin
        vec_t v;
        int   prev_cnt;

        vt[0] = mk("empty",   4, 8,  8'h00, 0, 0, 0, 0, 0,  0, 0);
        vt[1] = mk("two_pix", 4, 8,  8'h7F, 2, 5, 1, 3, 2,  1, 0);
        vt[1].mask[1][2] = 1'b1;
        vt[1].mask[3][5] = 1'b1;
        vt[2] = mk("fifteen", 4, 8,  8'h00, 0, 7, 0, 1, 15, 1, 0);
        for (int x = 0; x < 8; x++) vt[2].mask[0][x] = 1'b1;
        for (int x = 0; x < 7; x++) vt[2].mask[1][x] = 1'b1;
        vt[3] = mk("out_roi", 5, 10, 8'h00, 3, 6, 0, 2, 2,  1, 0);
        vt[3].mask[0][9] = 1'b1;
        vt[3].mask[0][3] = 1'b1;
        vt[3].mask[2][6] = 1'b1;
        vt[3].mask[4][1] = 1'b1;
        vt[4] = mk("sixteen", 4, 8,  8'h00, 0, 7, 0, 1, 16, 1, 1);
        for (int x = 0; x < 8; x++) begin
            vt[4].mask[0][x] = 1'b1;
            vt[4].mask[1][x] = 1'b1;
        end
        vt[5] = mk("href_only", 4, 8, 8'h00, 4, 4, 1, 1, 1, 1, 0);
        vt[5].no_clk[0] = 1'b1;
        vt[5].mask[1][4] = 1'b1;

        // Reset, open a frame, reset again mid-frame: the partial frame must vanish.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        frame_boundary(3);
        check("first_vsync_no_pulse", npulse, 0);
        v = vt[4];
        v.nl = 2;
        drive_frame(v);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_valid", a_valid, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_found", a_found, 0);
        @(negedge clk);
        rst = 1'b0;
        frame_boundary(3);
        check("post_rst_vsync_no_pulse", npulse, 0);
        check("post_rst_cnt", a_cnt, 0);

        prev_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive_frame(vt[i]);
            check($sformatf("%s.hold_cnt", vt[i].name), a_cnt, prev_cnt);
            check($sformatf("%s.idle_valid", vt[i].name), a_valid, 0);
            frame_boundary(3);
            check($sformatf("%s.pulses", vt[i].name), npulse, 1);
            if (i == 0) check("latency", first_at, 2);
            check($sformatf("%s.x_min", vt[i].name), a_xmin, vt[i].xmin);
            check($sformatf("%s.x_max", vt[i].name), a_xmax, vt[i].xmax);
            check($sformatf("%s.y_min", vt[i].name), a_ymin, vt[i].ymin);
            check($sformatf("%s.y_max", vt[i].name), a_ymax, vt[i].ymax);
            check($sformatf("%s.count", vt[i].name), a_cnt, vt[i].cnt);
            check($sformatf("%s.found_min1", vt[i].name), a_found, vt[i].f1);
            check($sformatf("%s.found_min16", vt[i].name), b_found, vt[i].f16);
            check($sformatf("%s.count_min16", vt[i].name), b_cnt, vt[i].cnt);
            check($sformatf("%s.x_max_min16", vt[i].name), b_xmax, vt[i].xmax);
            prev_cnt = vt[i].cnt;
        end

        // Long vsync with a foreground pixel driven on the LATCH cycle.
        v = mk("pre_long", 4, 8, 8'h00, 3, 3, 2, 2, 1, 1, 0);
        v.mask[2][3] = 1'b1;
        drive_frame(v);
        @(negedge clk);
        vsync = 1'b1;
        npulse = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (a_valid) npulse++;
            href  = (i == 1);
            clken = (i == 1);
            pix   = (i == 1) ? 8'hFF : 8'h00;
            if (i == 20) vsync = 1'b0;
        end
        check("long_vsync.pulses", npulse, 1);
        check("long_vsync.count", a_cnt, 1);
        check("long_vsync.x_min", a_xmin, 3);
        check("long_vsync.y_max", a_ymax, 2);
        drive_frame(vt[0]);
        frame_boundary(3);
        check("latch_pix.count", a_cnt, 1);
        check("latch_pix.found", a_found, 1);
        check("latch_pix.x_max", a_xmax, 0);
        check("latch_pix.y_max", a_ymax, 0);

`ifdef DIFF_BBOX_OVERLAY_EN
        v = mk("ovl_box", 4, 8, 8'h00, 1, 3, 1, 2, 2, 1, 0);
        v.mask[1][1] = 1'b1;
        v.mask[2][3] = 1'b1;
        drive_frame(v);
        frame_boundary(3);
        check("ovl_box.x_min", a_xmin, 1);
        check("ovl_box.y_max", a_ymax, 2);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                @(negedge clk);
                if (x > 0) begin
                    check($sformatf("ovl_img(%0d,%0d)", x - 1, y), a_ov_img,
                          on_border(x - 1, y) ? 128 : (y * 16 + x - 1));
                    check("ovl_href", a_ov_hr, 1);
                end
                href = 1'b1; clken = 1'b1; pix = 8'(y * 16 + x);
            end
            @(negedge clk);
            check($sformatf("ovl_img(%0d,%0d)", W - 1, y), a_ov_img,
                  on_border(W - 1, y) ? 128 : (y * 16 + W - 1));
            href = 1'b0; clken = 1'b0; pix = 8'd0;
            @(negedge clk);
            check("ovl_clken_low", a_ov_ck, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/diff_bbox_detect.md
Name: diff_bbox_detect

Overview:
- Consumer of the binary frame-difference stream (8-bit 0/255 pixels with vsync/href/clken sync).
- Counts pixel coordinates, accumulates the bounding box and count of foreground pixels per frame.
- Publishes a latched box at every frame boundary for the single-moving-object tracker and overlay path.

Parameters:
- IMG_W, 640, active pixels per line; pixels at x >= IMG_W are ignored.
- IMG_H, 480, active lines per frame; lines at y >= IMG_H are ignored.
- MIN_PIX, 16, minimum foreground pixel count for box_found = 1 (noise rejection).
- CW, 11, coordinate width; must satisfy 2^CW > max(IMG_W, IMG_H).

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- per_frame_vsync  in  1  frame sync, active-high; rising edge = frame boundary.
- per_frame_href  in  1  line valid, active-high.
- per_frame_clken  in  1  pixel strobe, qualified by href.
- per_img_Bit  in  8  difference pixel; foreground when bit 7 = 1.
- post_box_valid  out  1  one-cycle pulse when the box outputs update.
- box_x_min, box_x_max, box_y_min, box_y_max  out  CW each  latched box of the previous frame.
- box_found  out  1  previous frame pixel count >= MIN_PIX.
- pix_count  out  20  latched foreground count, saturating at 2^20-1.

Behaviour:
- Reset: all outputs 0, accumulators cleared, FSM in IDLE. Reset mid-frame discards the partial frame. Nothing is latched until the first full frame.
- Edge detect: vsync and href registered once. vs_rise = vsync & ~vsync_d. hs_fall = ~href & href_d.
- x counter: increments on clken & href; clears on hs_fall and vs_rise; saturates at IMG_W.
- y counter: increments on hs_fall; clears on vs_rise; saturates at IMG_H.
- Accumulate on clken & href & bit7 & x < IMG_W & y < IMG_H:
  - min/max update against current x,y.
  - count += 1, saturating.
  - Clear values: min = all-ones, max = 0, count = 0.
- FSM states:
  - IDLE: on vs_rise, go to ACTIVE and clear accumulators.
  - ACTIVE: on vs_rise, go to LATCH.
  - LATCH (1 cycle): copy accumulators to outputs; box_found = (count >= MIN_PIX); pulse post_box_valid; clear accumulators; return to ACTIVE.
- Latency: post_box_valid asserts 2 clk after the cycle vsync first samples high.
- Outputs hold between pulses.
- A pixel qualified during the LATCH cycle belongs to the new frame: it is accumulated after the clear, with clear-then-update priority in the same cycle.
- Empty frame (count 0):
  - box_found = 0.
  - Coordinates output as x_min = y_min = 0 and x_max = y_max = 0, not all-ones.
- href with no clken toggles advances y only.
- A vsync high spanning many cycles triggers exactly one latch.

Optional Feature:
- Macro: DIFF_BBOX_OVERLAY_EN.
- Defined:
  - Adds outputs ovl_frame_vsync, ovl_frame_href, ovl_frame_clken (1 bit each) and ovl_img (8 bits).
  - These are the input stream delayed 1 clk.
  - ovl_img = 8'd128 when box_found and the pixel lies on the latched rectangle border (x equals x_min or x_max within [y_min, y_max], or y equals y_min or y_max within [x_min, x_max]); otherwise the delayed input pixel.
  - Overlay outputs reset to 0.
- Undefined: these ports and their logic are absent; the core behaviour is unchanged.

Decomposition:
- Package diff_pkg:
  - IMG_W/IMG_H defaults and CW.
  - FG_BIT index (7).
  - Count width (20).
  - FSM state enum (IDLE, ACTIVE, LATCH).
- One sub-module, sync_edge_det: registers vsync/href and emits vs_rise/hs_fall. It is reused by later projection blocks.

Test Plan:
- Reset asserted mid-frame, released, one empty 8x4 frame -> no post_box_valid until the second vs_rise; outputs stay 0; box_found = 0.
- IMG_W=8, IMG_H=4, MIN_PIX=1; foreground at (2,1) and (5,3) -> after the next vs_rise: pulse once; box 2..5 / 1..3; pix_count = 2; box_found = 1.
- MIN_PIX=16, 15 foreground pixels -> box_found = 0, pix_count = 15, coordinates still reported.
- Foreground at x = 9 on an IMG_W=8 line (line with 10 clken) and on a 5th line -> ignored; pix_count excludes them.
- vsync held high for 20 cycles, with a foreground pixel on the LATCH cycle -> exactly one pulse; that pixel appears in the next frame's count.
- DIFF_BBOX_OVERLAY_EN defined, latched box (1,1)-(3,2) -> border pixels read 128; others equal the input delayed 1 clk.
